fifo_ctrl: RTL

Pointer and status controller that sits directly upstream of regfile and turns it into a depth-2**w synchronous FIFO. It generates wr_en, w_addr and r_addr for regfile and tracks occupancy, full/empty and almost-full/almost-empty status. It also raises sticky overflow/underflow error flags and issues a read-data-valid strobe aligned to regfile's registered r_data.

---
 rtl/fifo_ctrl_if.sv | 32 +++
 rtl/fifo_ctrl.sv | 67 ++++++
 2 files changed

// File: rtl/fifo_ctrl_if.sv
// Handshake bundle between a producer/consumer and fifo_ctrl.
// The master modport is the user side; the slave modport is the controller.
interface fifo_ctrl_if #(
    parameter int w = 2
);
    logic         wr;
    logic         rd;
    logic         clr_err;
    logic         wr_en;
    logic [w-1:0] w_addr;
    logic [w-1:0] r_addr;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [w:0]   count;
    logic         rd_valid;
    logic         overflow;
    logic         underflow;

    modport master (
        output wr, rd, clr_err,
        input  wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
               count, rd_valid, overflow, underflow
    );

    modport slave (
        input  wr, rd, clr_err,
        output wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
               count, rd_valid, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/status controller that turns an external regfile into a 2**w deep FIFO.
// Status is derived from the registered occupancy count; only wr_en is combinational.
module fifo_ctrl #(
    parameter int w      = 2,
    parameter int AF_LVL = 3,
    parameter int AE_LVL = 1
) (
    input logic        clk,
    input logic        reset,
    fifo_ctrl_if.slave bus
);
    localparam logic [w:0] DEPTH_C = (w+1)'(2**w);
    localparam logic [w:0] AF_C    = (w+1)'(AF_LVL);
    localparam logic [w:0] AE_C    = (w+1)'(AE_LVL);

    logic [w-1:0] r_w_ptr;
    logic [w-1:0] r_r_ptr;
    logic [w:0]   r_count;
    logic         r_rd_valid;
    logic         r_overflow;
    logic         r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_full   = (r_count == DEPTH_C);
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = bus.rd & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign w_wr_acc = bus.wr & (~w_full | w_rd_acc);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, matching the regfile's read-old-data timing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w_ptr     <= '0;
            r_r_ptr     <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_w_ptr <= r_w_ptr + 1'b1;
            if (w_rd_acc) r_r_ptr <= r_r_ptr + 1'b1;
            if (w_wr_acc && !w_rd_acc)      r_count <= r_count + 1'b1;
            else if (!w_wr_acc && w_rd_acc) r_count <= r_count - 1'b1;
            r_rd_valid <= w_rd_acc;
            // Error set takes priority over a simultaneous clear.
            r_overflow  <= (bus.wr & ~w_wr_acc) | (r_overflow  & ~bus.clr_err);
            r_underflow <= (bus.rd & w_empty)   | (r_underflow & ~bus.clr_err);
        end
    end

    assign bus.wr_en        = w_wr_acc;
    assign bus.w_addr       = r_w_ptr;
    assign bus.r_addr       = r_r_ptr;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= AF_C);
    assign bus.almost_empty = (r_count <= AE_C);
    assign bus.rd_valid     = r_rd_valid;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule
